// File: rtl/cand_buffer.sv
// cand_buffer: slot-based candidate storage feeding the mapping table.
// Writes land in the lowest free slot; the selector picks a slot by index,
// whose payload is moved into a one-entry output register and the slot freed.
// Optional feature macro: CAND_BUF_ERR_CNT_EN adds a saturating 16-bit
// counter of empty-slot selections (err_cnt).
module cand_buffer #(
    parameter int bs = 16,
    parameter int DW = 32,
    localparam int bs_bits = $clog2(bs)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [DW-1:0]      wr_data,
    output logic               wr_ready,
    output logic [bs-1:0]      cand_list,
    input  logic               sel_valid,
    input  logic [bs_bits-1:0] sel_index,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [bs_bits-1:0] out_index,
    input  logic               out_ready,
    output logic [bs_bits:0]   count,
    output logic               full,
    output logic               empty,
`ifdef CAND_BUF_ERR_CNT_EN
    output logic [15:0]        err_cnt,
`endif
    output logic               sel_err
);

    localparam int CW = bs_bits + 1;

    logic [bs-1:0]         valid;
    logic [bs-1:0][DW-1:0] mem;

    logic                  wr_fire;
    logic [bs_bits-1:0]    wr_slot;
    logic [bs-1:0]         wr_mask;
    logic                  load_ok;
    logic                  sel_take;
    logic                  sel_hit;
    logic                  sel_miss;
    logic [bs-1:0]         sel_mask;
    logic [bs-1:0]         valid_nxt;
    logic [CW-1:0]         count_nxt;

    assign cand_list = valid;
    assign wr_ready  = !full;
    assign wr_fire   = wr_valid && !full;
    assign load_ok   = !out_valid || out_ready;
    assign sel_take  = sel_valid && load_ok;
    assign sel_hit   = sel_take && valid[sel_index];
    assign sel_miss  = sel_take && !valid[sel_index];

    // Lowest-index free slot, taken from the pre-edge valid vector so it can
    // never collide with a slot being selected in the same cycle.
    always_comb begin
        wr_slot = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid[i]) wr_slot = bs_bits'(i);
        end
    end

    // Set/clear masks and the next occupancy figures.
    always_comb begin
        wr_mask   = wr_fire ? (bs'(1) << wr_slot) : '0;
        sel_mask  = sel_hit ? (bs'(1) << sel_index) : '0;
        valid_nxt = (valid | wr_mask) & ~sel_mask;
        count_nxt = count + CW'(wr_fire) - CW'(sel_hit);
    end

    // Slot storage and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            mem   <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_fire) mem[wr_slot] <= wr_data;
            valid <= valid_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(bs));
            empty <= (count_nxt == '0);
        end
    end

    // One-entry output register; a hit reloads it, a bare handshake drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= sel_miss;
            if (sel_hit) begin
                out_valid <= 1'b1;
                out_data  <= mem[sel_index];
                out_index <= sel_index;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CAND_BUF_ERR_CNT_EN
    // Saturating count of empty-slot selections.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (sel_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cand_buffer.sv
module tb_cand_buffer;

  localparam int bs = 16;
  localparam int DW = 32;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [bs-1:0] cand_list;
  logic          sel_valid;
  logic [BB-1:0] sel_index;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [BB-1:0] out_index;
  logic          out_ready;
  logic [BB:0]   count;
  logic          full;
  logic          empty;
  logic          sel_err;
`ifdef CAND_BUF_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  cand_buffer #(.bs(bs), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cand_list(cand_list),
    .sel_valid(sel_valid), .sel_index(sel_index),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
`ifdef CAND_BUF_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    sel_valid = 1'b0; sel_index = '0; out_ready = 1'b0;
    #3;
    chk("rst_cand", cand_list, 16'h0000);
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sel_err", sel_err, 1'b0);
    step();
    rst = 1'b0;

    wr_valid = 1'b1;
    wr_data = 32'hA; step();
    wr_data = 32'hB; step();
    wr_data = 32'hC; step();
    wr_valid = 1'b0;
    chk("w3_cand", cand_list, 16'h0007);
    chk("w3_count", count, 5'd3);
    chk("w3_wr_ready", wr_ready, 1'b1);
    chk("w3_out_valid", out_valid, 1'b0);
    chk("w3_empty", empty, 1'b0);

    wr_valid = 1'b1;
    for (int i = 3; i < bs; i++) begin
      wr_data = 32'h100 + 32'(i);
      step();
    end
    chk("fill_full", full, 1'b1);
    chk("fill_wr_ready", wr_ready, 1'b0);
    chk("fill_count", count, 5'd16);
    chk("fill_cand", cand_list, 16'hFFFF);
    wr_data = 32'hFF; step();
    wr_valid = 1'b0;
    chk("ovf_count", count, 5'd16);
    chk("ovf_cand", cand_list, 16'hFFFF);

    sel_valid = 1'b1; sel_index = 4'd5; step();
    sel_valid = 1'b0;
    chk("s5_out_valid", out_valid, 1'b1);
    chk("s5_out_data", out_data, 32'h105);
    chk("s5_out_index", out_index, 4'd5);
    chk("s5_cand", cand_list, 16'hFFDF);
    chk("s5_count", count, 5'd15);
    chk("s5_wr_ready", wr_ready, 1'b1);
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    chk("s5_drain", out_valid, 1'b0);

    sel_valid = 1'b1; sel_index = 4'd2; step();
    chk("s2_out_data", out_data, 32'hC);
    sel_index = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, 32'hC);
      chk("hold_index", out_index, 4'd2);
      chk("hold_bit3", cand_list[3], 1'b1);
      chk("hold_sel_err", sel_err, 1'b0);
    end
    sel_valid = 1'b0;
    out_ready = 1'b1; step();
    chk("hold_drain", out_valid, 1'b0);
    chk("hold_count", count, 5'd14);
    chk("hold_cand", cand_list, 16'hFFDB);

    sel_valid = 1'b1; sel_index = 4'd7; step();
    chk("s7_out_data", out_data, 32'h107);
    step();
    sel_valid = 1'b0;
    chk("miss_sel_err", sel_err, 1'b1);
    chk("miss_out_valid", out_valid, 1'b0);
    chk("miss_count", count, 5'd13);
    chk("miss_cand", cand_list, 16'hFF5B);
    step();
    chk("miss_pulse_end", sel_err, 1'b0);
`ifdef CAND_BUF_ERR_CNT_EN
    chk("err_cnt", err_cnt, 16'd1);
`endif

    sel_valid = 1'b1;
    for (int i = 8; i < 12; i++) begin
      sel_index = BB'(i);
      step();
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_data", out_data, 32'h100 + 32'(i));
    end
    sel_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("b2b_count", count, 5'd9);
    chk("b2b_hold", out_valid, 1'b1);

    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_cand", cand_list, 16'h0000);
    chk("arst_count", count, 5'd0);
    chk("arst_out_data", out_data, 32'h0);
    #2 rst = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h77; step();
    chk("arst_first_slot", cand_list, 16'h0001);

    wr_data = 32'h30; step();
    wr_data = 32'h31; step();
    wr_data = 32'h32; step();
    chk("c4_count", count, 5'd4);
    chk("c4_cand", cand_list, 16'h000F);
    wr_data = 32'h55; sel_valid = 1'b1; sel_index = 4'd1; step();
    sel_valid = 1'b0;
    chk("ws_count", count, 5'd4);
    chk("ws_cand", cand_list, 16'h001D);
    chk("ws_out_data", out_data, 32'h30);
    chk("ws_out_index", out_index, 4'd1);
    out_ready = 1'b1; wr_data = 32'h66; step();
    wr_valid = 1'b0;
    chk("reuse_cand", cand_list, 16'h001F);
    chk("reuse_drain", out_valid, 1'b0);
    sel_valid = 1'b1; sel_index = 4'd4; step();
    chk("rd4_data", out_data, 32'h55);
    sel_index = 4'd1; step();
    chk("rd1_data", out_data, 32'h66);
    sel_index = 4'd0; step();
    chk("rd0_data", out_data, 32'h77);
    sel_valid = 1'b0; step();
    chk("end_count", count, 5'd2);
    chk("end_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
